// File: rtl/jk_excite_driver.sv
// jk_excite_driver
//   Write-side controller for a bank of WIDTH external JK flip-flops. A target word is
//   accepted over a valid/ready handshake. The block derives per-bit J/K excitation from
//   the bank's fed-back q and pulses j/k for exactly one cycle. It then waits SETTLE idle
//   cycles and compares q against the target. On a mismatch it re-drives up to MAX_RETRY
//   times and finishes with a one-cycle done or err pulse.
//
//   Optional build macro: JK_TOGGLE_EXCITE_EN
//     defined   - mismatched bits are driven j=k=1 (toggle), matched bits j=k=0
//     undefined - set/reset excitation: j = ~q & t, k = q & ~t
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   tgt_valid  in   target word valid
//   tgt_ready  out  idle and able to accept a target (registered)
//   tgt_data   in   desired q of the bank [WIDTH]
//   q_fb       in   current q of the JK bank [WIDTH]
//   j, k       out  J/K inputs to the bank, nonzero only during DRIVE [WIDTH]
//   busy       out  high whenever the block is not idle
//   done       out  one-cycle pulse, bank verified equal to target
//   err        out  one-cycle pulse, retries exhausted with a mismatch
//   fail_bits  out  q_fb ^ target at the failing check, held until the next acceptance
module jk_excite_driver #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SETTLE    = 2,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] fail_bits
);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck
    } state_e;

    // Last value of the settle counter; unused when SETTLE is 0 because SETTLE is skipped.
    localparam logic [3:0] SettleLast = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [2:0] MaxRetry   = 3'(MAX_RETRY);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_tgt, w_tgt_nxt;
    logic [2:0]       r_retry, w_retry_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_fail, w_fail_nxt;
    logic [WIDTH-1:0] r_j, w_j_nxt;
    logic [WIDTH-1:0] r_k, w_k_nxt;
    logic             r_ready, w_ready_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    // Returns {j, k} for driving the bank from q toward t.
    function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_EXCITE_EN
        return {q ^ t, q ^ t};
`else
        return {~q & t, q & ~t};
`endif
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_retry_nxt = r_retry;
        w_cnt_nxt   = r_cnt;
        w_fail_nxt  = r_fail;
        w_j_nxt     = '0;
        w_k_nxt     = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (tgt_valid && r_ready) begin
                    w_tgt_nxt   = tgt_data;
                    w_retry_nxt = '0;
                    w_fail_nxt  = '0;
                    w_state_nxt = StDrive;
                    // j/k are registered, so they are computed here to be valid in DRIVE.
                    {w_j_nxt, w_k_nxt} = excite(q_fb, tgt_data);
                end
            end
            StDrive: begin
                w_cnt_nxt   = '0;
                w_state_nxt = (SETTLE == 0) ? StCheck : StSettle;
            end
            StSettle: begin
                if (r_cnt == SettleLast) begin
                    w_state_nxt = StCheck;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            StCheck: begin
                if (q_fb == r_tgt) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end else if (r_retry < MaxRetry) begin
                    w_retry_nxt = r_retry + 3'd1;
                    w_state_nxt = StDrive;
                    // Recompute from the present q so a stale toggle gets corrected.
                    {w_j_nxt, w_k_nxt} = excite(q_fb, r_tgt);
                end else begin
                    w_fail_nxt  = q_fb ^ r_tgt;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        w_ready_nxt = (w_state_nxt == StIdle);
        w_busy_nxt  = (w_state_nxt != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_tgt   <= '0;
            r_retry <= '0;
            r_cnt   <= '0;
            r_fail  <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_retry <= w_retry_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fail  <= w_fail_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign tgt_ready = r_ready;
    assign j         = r_j;
    assign k         = r_k;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign fail_bits = r_fail;

endmodule
